// File: rtl/his_builder_reg_pkg.sv
// his_builder_reg_pkg: shared defaults and dataFinish bit positions for the histogram stage
package his_builder_reg_pkg;
    localparam int NB_DEF       = 4;
    localparam int PEAK_MAX_DEF = 8;
    localparam int CH_BIT       = 1;
    localparam int FH_BIT       = 0;
endpackage

// File: rtl/his_builder_reg_peak_detecter.sv
// peak_detecter: running maximum count and its bin index for one histogram
module peak_detecter
    import his_builder_reg_pkg::*;
#(
    parameter int NB       = NB_DEF,
    parameter int PEAK_MAX = PEAK_MAX_DEF
) (
    input  logic                clk,
    input  logic                res,
    input  logic                wr,
    input  logic [PEAK_MAX-1:0] count,
    input  logic [NB-1:0]       bin,
    output logic [NB-1:0]       maxIdx
);
    logic [PEAK_MAX-1:0] maxVal;

    // strictly-greater update so the earliest bin to reach a maximum keeps it
    always_ff @(posedge clk) begin
        if (res) begin
            maxVal <= '0;
            maxIdx <= '0;
        end else if (wr && count > maxVal) begin
            maxVal <= count;
            maxIdx <= bin;
        end
    end
endmodule

// File: rtl/his_builder_reg.sv
// his_builder_reg: coarse/fine histograms with running peaks, finish latch and clamped peak offset
module his_builder_reg
    import his_builder_reg_pkg::*;
#(
    parameter int NB       = NB_DEF,
    parameter int PEAK_MAX = PEAK_MAX_DEF
) (
    input  logic                clk,
    input  logic                res,
    input  logic [1:0]          wrEnable,
    input  logic                acqFinish,
    input  logic [NB-1:0]       addr,
    input  logic [NB-1:0]       THminus,
    input  logic [NB-1:0]       THpositive,
    output logic [PEAK_MAX-1:0] binCounts,
    output logic [1:0]          dataFinish,
    output logic [NB-1:0]       peakCH,
    output logic [NB-1:0]       peakFH,
    output logic [NB:0]         delta
);
    logic [PEAK_MAX-1:0] chBins [2**NB];
    logic [PEAK_MAX-1:0] fhBins [2**NB];
    logic [PEAK_MAX-1:0] chCur, fhCur, chInc, fhInc;
    logic                chWr, fhWr, finStart, finPend;
    logic [NB-1:0]       idxCH, idxFH;
    logic signed [NB+1:0] diff, lo, hi, clamped;

    // saturating increments, write qualification and the clamped fine-minus-coarse offset
    always_comb begin
        chCur     = chBins[addr];
        fhCur     = fhBins[addr];
        chInc     = (chCur == '1) ? chCur : chCur + 1'b1;
        fhInc     = (fhCur == '1) ? fhCur : fhCur + 1'b1;
        chWr      = wrEnable[CH_BIT] && addr != '0 && !acqFinish && !dataFinish[CH_BIT];
        fhWr      = wrEnable[FH_BIT] && addr != '0 && !acqFinish && !dataFinish[FH_BIT];
        finStart  = acqFinish && dataFinish == 2'b00;
        binCounts = (addr == '0) ? '0 : chWr ? chInc : chCur;
        diff      = $signed({2'b00, idxFH}) - $signed({2'b00, idxCH});
        lo        = -$signed({2'b00, THminus});
        hi        = $signed({2'b00, THpositive});
        clamped   = (diff < lo) ? lo : (diff > hi) ? hi : diff;
    end

    // histogram storage, sticky finish flags and peak latch one edge after finish
    always_ff @(posedge clk) begin
        if (res) begin
            for (int i = 0; i < 2**NB; i++) begin
                chBins[i] <= '0;
                fhBins[i] <= '0;
            end
            dataFinish <= 2'b00;
            finPend    <= 1'b0;
            peakCH     <= '0;
            peakFH     <= '0;
            delta      <= '0;
        end else begin
            if (chWr) chBins[addr] <= chInc;
            if (fhWr) fhBins[addr] <= fhInc;
            if (finStart) dataFinish <= 2'b11;
            finPend <= finStart;
            if (finPend) begin
                peakCH <= idxCH;
                peakFH <= idxFH;
                delta  <= clamped[NB:0];
            end
        end
    end

    peak_detecter #(.NB(NB), .PEAK_MAX(PEAK_MAX)) chPeak (
        .clk(clk), .res(res), .wr(chWr), .count(chInc), .bin(addr), .maxIdx(idxCH)
    );

    peak_detecter #(.NB(NB), .PEAK_MAX(PEAK_MAX)) fhPeak (
        .clk(clk), .res(res), .wr(fhWr), .count(fhInc), .bin(addr), .maxIdx(idxFH)
    );
endmodule

// File: tb/tb_his_builder_reg.sv
// tb_his_builder_reg: directed vectors with hand-computed expectations for his_builder_reg
module tb_his_builder_reg;
    logic       clk = 1'b0;
    logic       res = 1'b1;
    logic [1:0] wrEnable = 2'b00;
    logic       acqFinish = 1'b0;
    logic [3:0] addr = 4'd0;
    logic [3:0] THminus = 4'd7;
    logic [3:0] THpositive = 4'd7;
    logic [7:0] binCounts;
    logic [1:0] dataFinish;
    logic [3:0] peakCH, peakFH;
    logic [4:0] delta;
    logic [1:0] satBinCounts;
    logic [1:0] satDataFinish;
    logic [3:0] satPeakCH, satPeakFH;
    logic [4:0] satDelta;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    his_builder_reg dut (
        .clk(clk), .res(res), .wrEnable(wrEnable), .acqFinish(acqFinish), .addr(addr),
        .THminus(THminus), .THpositive(THpositive), .binCounts(binCounts),
        .dataFinish(dataFinish), .peakCH(peakCH), .peakFH(peakFH), .delta(delta)
    );

    his_builder_reg #(.NB(4), .PEAK_MAX(2)) dutSat (
        .clk(clk), .res(res), .wrEnable(wrEnable), .acqFinish(acqFinish), .addr(addr),
        .THminus(THminus), .THpositive(THpositive), .binCounts(satBinCounts),
        .dataFinish(satDataFinish), .peakCH(satPeakCH), .peakFH(satPeakFH), .delta(satDelta)
    );

    task automatic checkVal(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // inputs change just after the falling edge; outputs are read 1ns later
    task automatic drive(input logic [1:0] we, input logic af, input logic [3:0] a);
        @(negedge clk);
        wrEnable  = we;
        acqFinish = af;
        addr      = a;
        #1;
    endtask

    task automatic doReset();
        res = 1'b1;
        drive(2'b00, 1'b0, 4'd0);
        drive(2'b00, 1'b0, 4'd0);
        res = 1'b0;
    endtask

    task automatic finishAndWait();
        drive(2'b00, 1'b1, 4'd0);
        drive(2'b00, 1'b0, 4'd0);
        drive(2'b00, 1'b0, 4'd0);
    endtask

    initial begin
        doReset();
        checkVal("rst_dataFinish", 16'(dataFinish), 16'h0);
        checkVal("rst_peakCH", 16'(peakCH), 16'h0);
        checkVal("rst_peakFH", 16'(peakFH), 16'h0);
        checkVal("rst_delta", 16'(delta), 16'h0);

        for (int i = 1; i <= 3; i++) begin
            drive(2'b11, 1'b0, 4'd1);
            checkVal("main_bin1", 16'(binCounts), 16'(i));
        end
        for (int i = 1; i <= 4; i++) begin
            drive(2'b11, 1'b0, 4'd2);
            checkVal("main_bin2", 16'(binCounts), 16'(i));
        end
        for (int i = 1; i <= 3; i++) begin
            drive(2'b11, 1'b0, 4'd3);
            checkVal("main_bin3", 16'(binCounts), 16'(i));
        end
        drive(2'b00, 1'b1, 4'd0);
        checkVal("main_pre_fin", 16'(dataFinish), 16'h0);
        drive(2'b00, 1'b0, 4'd0);
        checkVal("main_dataFinish", 16'(dataFinish), 16'h3);
        checkVal("main_peak_lag", 16'(peakCH), 16'h0);
        drive(2'b00, 1'b0, 4'd0);
        checkVal("main_peakCH", 16'(peakCH), 16'h2);
        checkVal("main_peakFH", 16'(peakFH), 16'h2);
        checkVal("main_delta", 16'(delta), 16'h0);

        doReset();
        drive(2'b11, 1'b0, 4'd1);
        drive(2'b11, 1'b0, 4'd1);
        drive(2'b11, 1'b0, 4'd3);
        drive(2'b11, 1'b0, 4'd3);
        finishAndWait();
        checkVal("tie_peakCH", 16'(peakCH), 16'h1);
        checkVal("tie_peakFH", 16'(peakFH), 16'h1);

        doReset();
        drive(2'b11, 1'b0, 4'd1);
        drive(2'b11, 1'b0, 4'd1);
        drive(2'b11, 1'b1, 4'd2);
        checkVal("fin_addr2_bc", 16'(binCounts), 16'h0);
        drive(2'b11, 1'b0, 4'd2);
        checkVal("fin_after_bc", 16'(binCounts), 16'h0);
        checkVal("fin_dataFinish", 16'(dataFinish), 16'h3);
        drive(2'b11, 1'b0, 4'd2);
        drive(2'b11, 1'b0, 4'd2);
        checkVal("fin_peakCH", 16'(peakCH), 16'h1);
        drive(2'b11, 1'b1, 4'd2);
        drive(2'b11, 1'b0, 4'd2);
        drive(2'b00, 1'b0, 4'd1);
        checkVal("fin_ignored_bc", 16'(binCounts), 16'h2);
        checkVal("fin_hold_peakCH", 16'(peakCH), 16'h1);
        checkVal("fin_hold_peakFH", 16'(peakFH), 16'h1);
        checkVal("fin_hold_df", 16'(dataFinish), 16'h3);

        doReset();
        drive(2'b11, 1'b0, 4'd3);
        drive(2'b11, 1'b0, 4'd3);
        drive(2'b11, 1'b0, 4'd3);
        doReset();
        drive(2'b00, 1'b0, 4'd3);
        checkVal("midrst_bin3", 16'(binCounts), 16'h0);
        drive(2'b11, 1'b0, 4'd1);
        checkVal("midrst_bin1", 16'(binCounts), 16'h1);
        drive(2'b11, 1'b0, 4'd0);
        checkVal("midrst_addr0", 16'(binCounts), 16'h0);
        finishAndWait();
        checkVal("midrst_peakCH", 16'(peakCH), 16'h1);
        checkVal("midrst_peakFH", 16'(peakFH), 16'h1);
        drive(2'b00, 1'b0, 4'd1);
        checkVal("midrst_bin1_held", 16'(binCounts), 16'h1);

        THminus = 4'd1;
        doReset();
        drive(2'b10, 1'b0, 4'd3);
        drive(2'b10, 1'b0, 4'd3);
        finishAndWait();
        checkVal("ch_only_peakCH", 16'(peakCH), 16'h3);
        checkVal("ch_only_peakFH", 16'(peakFH), 16'h0);
        checkVal("clamp_neg1", 16'(delta), 16'h1F);

        THminus = 4'd7;
        doReset();
        drive(2'b10, 1'b0, 4'd3);
        drive(2'b10, 1'b0, 4'd3);
        finishAndWait();
        checkVal("noclamp_neg3", 16'(delta), 16'h1D);

        THpositive = 4'd2;
        doReset();
        drive(2'b01, 1'b0, 4'd5);
        finishAndWait();
        checkVal("fh_only_peakFH", 16'(peakFH), 16'h5);
        checkVal("clamp_pos2", 16'(delta), 16'h2);

        doReset();
        finishAndWait();
        checkVal("empty_peakCH", 16'(peakCH), 16'h0);
        checkVal("empty_delta", 16'(delta), 16'h0);

        doReset();
        for (int i = 1; i <= 5; i++) begin
            drive(2'b11, 1'b0, 4'd1);
            checkVal("sat_bc", 16'(satBinCounts), 16'(i > 3 ? 3 : i));
            checkVal("wide_bc", 16'(binCounts), 16'(i));
        end
        finishAndWait();
        checkVal("sat_peakCH", 16'(satPeakCH), 16'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
